hls_invoker: RTL and testbench

HLS_INVOKER -- requirements
Module: hls_invoker

---
 rtl/hls_pkg.sv | 15 +
 rtl/hls_invoker_if.sv | 27 ++
 rtl/hls_cycle_counter.sv | 42 ++++
 rtl/hls_invoker.sv | 93 +++++++++
 tb/tb_hls_invoker.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/hls_pkg.sv
// Shared types and constants for the HLS kernel invoker: FSM state
// encoding, default data width and the width of the reported cycle count.
package hls_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      RESP
   } state_t;

   localparam int DATA_W_DEF = 32;
   localparam int CYC_W      = 16;

endpackage

// File: rtl/hls_invoker_if.sv
// Host-side launch request / response handshake bundle of the invoker.
interface hls_invoker_if
   import hls_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
);

   logic              req_valid;
   logic              req_ready;
   logic [DATA_W-1:0] req_n;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_data;
   logic              resp_timeout;
   logic [CYC_W-1:0]  resp_cycles;

   modport master (
      output req_valid, req_n, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_timeout, resp_cycles
   );

   modport slave (
      input  req_valid, req_n, resp_ready,
      output req_ready, resp_valid, resp_data, resp_timeout, resp_cycles
   );

endinterface

// File: rtl/hls_cycle_counter.sv
// RUN-phase cycle counter: clear/enable, saturating 16-bit view of the count
// and a terminal-count flag raised when the count equals TIMEOUT-1.
module hls_cycle_counter
   import hls_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [CYC_W-1:0] count,
   output logic             tc
);

   // Internal width covers both TIMEOUT-1 and the full reported range.
   localparam int CW = ($clog2(TIMEOUT) > CYC_W) ? $clog2(TIMEOUT) : CYC_W;

   logic [CW-1:0] cnt;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (&v) ? v : v + CW'(1);
   endfunction

   function automatic logic [CYC_W-1:0] sat_out(input logic [CW-1:0] v);
      return (v > CW'({CYC_W{1'b1}})) ? {CYC_W{1'b1}} : v[CYC_W-1:0];
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= sat_inc(cnt);
      end
   end

   assign count = sat_out(cnt);
   assign tc    = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/hls_invoker.sv
// Launches an HLS-generated kernel: latches the argument, pulses the kernel
// reset, waits for done or timeout, and holds the result until accepted.
module hls_invoker
   import hls_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 1024
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   hls_invoker_if.slave      host,
   output logic              kern_rst_n,
   output logic [DATA_W-1:0] kern_n,
   input  logic [DATA_W-1:0] kern_return_val,
   input  logic              kern_done
);

   localparam int LW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t            state, next;
   logic [LW-1:0]     load_cnt;
   logic              ready_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic              timeout_q;
   logic [CYC_W-1:0]  cycles_q;
   logic [CYC_W-1:0]  run_cycles;
   logic              run_tc;

   hls_cycle_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .clr   (state != RUN),
      .en    (state == RUN),
      .count (run_cycles),
      .tc    (run_tc)
   );

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state <= IDLE;
      end else begin
         state <= next;
      end
   end

   // kern_done outranks the terminal count when both arrive together.
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (host.req_valid && ready_q) next = LOAD;
         LOAD:    if (load_cnt == LW'(RST_CYCLES - 1)) next = RUN;
         RUN:     if (kern_done || run_tc) next = RESP;
         RESP:    if (host.resp_ready) next = IDLE;
         default: next = IDLE;
      endcase
   end

   // Handshake and kernel-reset outputs are registered from the next state.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         ready_q    <= 1'b0;
         kern_rst_n <= 1'b0;
         valid_q    <= 1'b0;
         load_cnt   <= '0;
         kern_n     <= '0;
         data_q     <= '0;
         timeout_q  <= 1'b0;
         cycles_q   <= '0;
      end else begin
         ready_q    <= (next == IDLE);
         kern_rst_n <= (next == RUN);
         valid_q    <= (next == RESP);
         load_cnt   <= (state == LOAD) ? load_cnt + LW'(1) : '0;
         if (state == IDLE && next == LOAD) begin
            kern_n <= host.req_n;
         end
         if (state == RUN && next == RESP) begin
            data_q    <= kern_done ? kern_return_val : '0;
            timeout_q <= !kern_done;
            cycles_q  <= run_cycles;
         end
      end
   end

   assign host.req_ready    = ready_q;
   assign host.resp_valid   = valid_q;
   assign host.resp_data    = data_q;
   assign host.resp_timeout = timeout_q;
   assign host.resp_cycles  = cycles_q;

endmodule

// File: tb/tb_hls_invoker.sv
// Bench for hls_invoker with a behavioural sum kernel (1+..+n, done in the
// (n+1)-th released cycle), a response-queue model and directed launches.
module tb_hls_invoker;

   localparam int DW  = 32;
   localparam int RSTC = 2;
   localparam int TMO = 16;

   logic          clk;
   logic          sys_rst;
   logic          kern_rst_n;
   logic [DW-1:0] kern_n;
   logic [DW-1:0] kern_return_val;
   logic          kern_done;
   logic          tie0;

   int checks = 0;
   int errors = 0;

   hls_invoker_if #(.DATA_W(DW)) bus ();

   hls_invoker #(.DATA_W(DW), .RST_CYCLES(RSTC), .TIMEOUT(TMO)) dut (
      .sys_clk         (clk),
      .sys_rst         (sys_rst),
      .host            (bus),
      .kern_rst_n      (kern_rst_n),
      .kern_n          (kern_n),
      .kern_return_val (kern_return_val),
      .kern_done       (kern_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural sum kernel, held in reset while kern_rst_n is low.
   logic [DW-1:0] k_cyc, k_acc;
   always_ff @(posedge clk) begin
      if (!kern_rst_n) begin
         k_cyc <= '0;
         k_acc <= '0;
      end else if (k_cyc < kern_n) begin
         k_cyc <= k_cyc + 1;
         k_acc <= k_acc + k_cyc + 1;
      end
   end
   assign kern_done       = !tie0 && kern_rst_n && (k_cyc == kern_n);
   assign kern_return_val = k_acc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each accepted launch yields one response in order.
   typedef struct {
      logic [DW-1:0] d;
      logic          to;
      logic [15:0]   c;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          e;
   logic          pend = 1'b0;
   int            low_cnt = 0;
   int            run_cnt = 0;
   logic          seen_valid = 1'b0;
   logic [DW-1:0] last_n = '0;

   always @(negedge clk) begin
      if (sys_rst) begin
         chk("reset_state", {bus.req_ready, kern_rst_n, kern_n, bus.resp_valid,
                             bus.resp_data, bus.resp_timeout, bus.resp_cycles}, '0);
         exp_q.delete();
         pend       = 1'b0;
         seen_valid = 1'b0;
         run_cnt    = 0;
         last_n     = '0;
      end else begin
         if (pend) begin
            if (!kern_rst_n) low_cnt++;
            else begin
               chk("kern_rst_pulse_len", low_cnt, RSTC);
               pend = 1'b0;
            end
         end
         if (kern_rst_n) run_cnt++;
         chk("kern_n_hold", kern_n, last_n);
         if (bus.resp_valid) begin
            chk("req_ready_in_resp", bus.req_ready, 0);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: resp_valid=1 with no launch outstanding");
            end else begin
               e = exp_q[0];
               if (!seen_valid) begin
                  chk("run_cycles_to_resp", run_cnt, e.c + 1);
                  seen_valid = 1'b1;
               end
               chk("resp_data", bus.resp_data, e.d);
               chk("resp_timeout", bus.resp_timeout, e.to);
               chk("resp_cycles", bus.resp_cycles, e.c);
               if (bus.resp_ready) begin
                  void'(exp_q.pop_front());
                  seen_valid = 1'b0;
               end
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            if (tie0 || bus.req_n > TMO - 1) begin
               e.d = '0; e.to = 1'b1; e.c = 16'(TMO - 1);
            end else begin
               e.d = bus.req_n * (bus.req_n + 1) / 2; e.to = 1'b0; e.c = bus.req_n[15:0];
            end
            exp_q.push_back(e);
            pend    = 1'b1;
            low_cnt = 0;
            run_cnt = 0;
            last_n  = bus.req_n;
         end
      end
   end

   task automatic launch(input logic [DW-1:0] n, input int hold,
                         input logic [DW-1:0] ed, input logic et, input logic [15:0] ec);
      int t;
      t = 0;
      while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
      chk("req_ready_wait", bus.req_ready, 1);
      bus.req_n     = n;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      chk("kern_n_latched", kern_n, n);
      t = 0;
      while (!bus.resp_valid && t < 100) begin @(posedge clk); #1; t++; end
      chk("resp_valid_wait", bus.resp_valid, 1);
      repeat (hold) begin @(posedge clk); #1; end
      chk("lit_resp_data", bus.resp_data, ed);
      chk("lit_resp_timeout", bus.resp_timeout, et);
      chk("lit_resp_cycles", bus.resp_cycles, ec);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk("resp_valid_drop", bus.resp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   logic          take, rv;
   logic [DW-1:0] d, r0, r1;
   int            acc, got;

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_n      = '0;
      bus.resp_ready = 1'b0;
      tie0           = 1'b0;
      sys_rst        = 1'b1;
      repeat (3) @(posedge clk);
      #1 sys_rst = 1'b0;
      chk("ready_before_edge", bus.req_ready, 0);
      @(posedge clk); #1;
      chk("ready_after_rst", bus.req_ready, 1);
      chk("kern_rst_n_idle", kern_rst_n, 0);

      launch(10, 0, 55, 0, 10);
      launch(0, 0, 0, 0, 0);
      tie0 = 1'b1;
      launch(7, 0, 0, 1, 15);
      tie0 = 1'b0;
      launch(15, 0, 120, 0, 15);
      launch(16, 0, 0, 1, 15);
      launch(5, 20, 15, 0, 5);

      // Abort an n=100 launch mid-RUN.
      bus.req_n     = 100;
      bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      chk("in_run_before_abort", kern_rst_n, 1);
      sys_rst = 1'b1;
      #1;
      chk("async_abort", {kern_rst_n, bus.resp_valid, bus.req_ready, kern_n}, '0);
      @(posedge clk); #1;
      sys_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("quiet_after_abort", {bus.resp_valid, kern_rst_n}, '0);
      end
      launch(3, 0, 6, 0, 3);

      // Back-to-back launches with req_valid held high.
      acc = 0;
      got = 0;
      r0  = '0;
      r1  = '0;
      bus.req_n      = 4;
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 200 && got < 2; c++) begin
         take = bus.req_ready && bus.req_valid;
         rv   = bus.resp_valid;
         d    = bus.resp_data;
         @(posedge clk); #1;
         if (take) begin
            acc++;
            if (acc == 1) bus.req_n = 6;
            else bus.req_valid = 1'b0;
         end
         if (rv) begin
            if (got == 0) r0 = d;
            else r1 = d;
            got++;
         end
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      chk("b2b_resp_count", got, 2);
      chk("b2b_first", r0, 10);
      chk("b2b_second", r1, 21);
      repeat (3) begin @(posedge clk); #1; end
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
